outerprodrc_ctrl: RTL and testbench
===================================

// Module: outerprodrc_ctrl
// PURPOSE
//   Job sequencer for the outerprodrc_vvm unary outer-product array.
//   - Accepts one (row vector, column vector) job over a valid/ready handshake.
//   - Sequences the array through clear, run and drain phases.
//   - Captures the array result and returns it over a valid/ready handshake.
//   - Sits between the host/scheduler and one outerprodrc_vvm instance, and owns the array's iEn, iClr and data inputs.
// PARAMETERS
//   ROWNUM      2   row-vector lanes
//   COLNUM      2   column-vector lanes
//   BITWIDTH    4   lane width, sign-magnitude (MSB = sign)
//   OUTBITWIDTH 8   width of each array output element
//   RUNLEN      8   enable cycles per job; nominally 2**(BITWIDTH-1); must be >= 1
//   DRAIN       1   idle cycles after the run before capture; 0..15 allowed
// PORTS
//   iClk       in   1                       clock, rising edge
//   iRst       in   1                       synchronous reset, active-high
//   iValid     in   1                       job request valid
//   oReady     out  1                       controller can accept a job
//   iData0     in   ROWNUM*BITWIDTH         job row vector
//   iData1     in   COLNUM*BITWIDTH         job column vector
//   iAbort     in   1                       cancel the current job
//   oValid     out  1                       result valid
//   iReady     in   1                       consumer accepts the result
//   oResult    out  ROWNUM*COLNUM*OUTBITWIDTH  captured array result
//   oBusy      out  1                       high when the state is not IDLE
//   oArrEn     out  1                       drives array iEn
//   oArrClr    out  1                       drives array iClr
//   oArrData0  out  ROWNUM*BITWIDTH         drives array iData0
//   oArrData1  out  COLNUM*BITWIDTH         drives array iData1
//   iArrData   in   ROWNUM*COLNUM*OUTBITWIDTH  array oData
// BEHAVIOUR
//   State machine: IDLE -> CLEAR -> RUN -> DRAIN -> DONE -> IDLE.
//   Reset:
//   - iRst high forces state IDLE on the next edge.
//   - The same edge zeroes the run counter, the drain counter, oResult, oArrData0 and oArrData1.
//   - While iRst is high, oReady, oValid, oBusy, oArrEn and oArrClr are 0.
//   - Reset mid-job drops the job silently; no result is produced.
//   IDLE:
//   - oReady = 1.
//   - On iValid & oReady: latch iData0/iData1 into oArrData0/oArrData1, then go to CLEAR.
//   - oArrData0/oArrData1 stay stable until the next accept.
//   CLEAR:
//   - Lasts exactly one cycle; oArrClr = 1, oArrEn = 0; then RUN.
//   RUN:
//   - oArrEn = 1 for exactly RUNLEN consecutive cycles.
//   - The run counter counts 0..RUNLEN-1 and is $clog2(RUNLEN+1) bits wide.
//   - At count RUNLEN-1, go to DRAIN, or to DONE if DRAIN == 0.
//   DRAIN:
//   - oArrEn = 0 for DRAIN cycles.
//   - On the transition into DONE, capture iArrData into oResult.
//   DONE:
//   - oValid = 1; oResult is held stable.
//   - On oValid & iReady, go to IDLE. The next job is accepted no earlier than the following cycle.
//   Latency:
//   - Accept at cycle t gives CLEAR at t+1 and RUN at t+2..t+1+RUNLEN.
//   - oValid first rises at t+2+RUNLEN+DRAIN (t+11 with the defaults).
//   iAbort:
//   - Sampled in CLEAR, RUN, DRAIN or DONE: go to IDLE on the next edge, with oArrEn = 0 and oValid = 0 from then on.
//   - In DONE, iAbort takes priority over iReady.
//   - In IDLE, iAbort is ignored, including when iValid is asserted in the same cycle.
//   - oResult keeps its previous value after an abort.
//   Other rules:
//   - oArrEn and oArrClr are never high in the same cycle.
//   - oReady and oValid are never high in the same cycle.
//   - iValid asserted while not in IDLE is ignored; the requester must hold it.
// TESTING
//   1. Reset: iRst=1 for 2 cycles, then 0 -> all outputs 0 during reset; oReady=1 on the first cycle after reset.
//   2. Basic job, defaults:
//      - Drive iData0={4'b1110,4'b0010}, iData1={4'b0100,4'b1100}, iValid pulse.
//      - Require: oArrClr high for 1 cycle; oArrEn high for exactly 8 cycles; oValid at accept+11.
//      - Require: oResult equals iArrData sampled as the controller enters DONE.
//   3. Backpressure: hold iReady=0 for 5 cycles in DONE -> oValid and oResult held; oReady stays 0; iValid is not accepted.
//   4. Abort in RUN: assert iAbort at the 4th enable cycle -> oArrEn drops next cycle; state IDLE; no oValid; the next job completes normally.
//   5. Back-to-back: iValid held high, iReady=1 -> a new accept every 12 cycles (RUNLEN=8, DRAIN=1); oArrData0/oArrData1 update only at accept.
//   6. Corners:
//      - DRAIN=0, RUNLEN=1: accept at t -> CLEAR at t+1, one enable cycle, oValid at t+3.
//      - Reset asserted during DRAIN -> IDLE; no result produced.

Source files
------------

// File: rtl/outerprodrc_ctrl.sv
// Job sequencer for one outerprodrc_vvm array: clear, run RUNLEN enables, drain, capture result.
// Result valid at accept+2+RUNLEN+DRAIN; held in DONE until iReady, and no job is accepted while busy.
module outerprodrc_ctrl #(
  parameter int ROWNUM      = 2,
  parameter int COLNUM      = 2,
  parameter int BITWIDTH    = 4,
  parameter int OUTBITWIDTH = 8,
  parameter int RUNLEN      = 8,
  parameter int DRAIN       = 1
) (
  input  logic                                  iClk,
  input  logic                                  iRst,
  input  logic                                  iValid,
  output logic                                  oReady,
  input  logic [ROWNUM*BITWIDTH-1:0]            iData0,
  input  logic [COLNUM*BITWIDTH-1:0]            iData1,
  input  logic                                  iAbort,
  output logic                                  oValid,
  input  logic                                  iReady,
  output logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0]  oResult,
  output logic                                  oBusy,
  output logic                                  oArrEn,
  output logic                                  oArrClr,
  output logic [ROWNUM*BITWIDTH-1:0]            oArrData0,
  output logic [COLNUM*BITWIDTH-1:0]            oArrData1,
  input  logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0]  iArrData
);

  localparam int RW = $clog2(RUNLEN + 1);
  localparam logic [RW-1:0] RUN_LAST   = RW'(RUNLEN - 1);
  localparam logic [3:0]    DRAIN_LAST = 4'(DRAIN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] run_cnt, run_cnt_nxt;
  logic [3:0]    drain_cnt, drain_cnt_nxt;
  logic          accept, capture;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= S_IDLE;
      run_cnt   <= '0;
      drain_cnt <= '0;
      oResult   <= '0;
      oArrData0 <= '0;
      oArrData1 <= '0;
    end else begin
      state     <= state_nxt;
      run_cnt   <= run_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (accept) begin
        oArrData0 <= iData0;
        oArrData1 <= iData1;
      end
      if (capture) oResult <= iArrData;
    end
  end

  always_comb begin
    state_nxt     = state;
    run_cnt_nxt   = run_cnt;
    drain_cnt_nxt = drain_cnt;
    accept        = 1'b0;
    capture       = 1'b0;
    case (state)
      S_IDLE: begin
        if (iValid) begin
          accept    = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        run_cnt_nxt = '0;
        state_nxt   = S_RUN;
      end
      S_RUN: begin
        if (run_cnt == RUN_LAST) begin
          drain_cnt_nxt = '0;
          if (DRAIN == 0) begin
            state_nxt = S_DONE;
            capture   = 1'b1;
          end else begin
            state_nxt = S_DRAIN;
          end
        end else begin
          run_cnt_nxt = run_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = S_DONE;
          capture   = 1'b1;
        end else begin
          drain_cnt_nxt = drain_cnt + 4'd1;
        end
      end
      S_DONE: begin
        if (iReady) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort wins over every other transition, including the result capture.
    if (iAbort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      capture   = 1'b0;
    end
  end

  assign oReady  = !iRst && state == S_IDLE;
  assign oValid  = !iRst && state == S_DONE;
  assign oBusy   = !iRst && state != S_IDLE;
  assign oArrEn  = !iRst && state == S_RUN;
  assign oArrClr = !iRst && state == S_CLEAR;

endmodule

// File: tb/tb_outerprodrc_ctrl.sv
// Bench for outerprodrc_ctrl: instance 0 uses defaults (RUNLEN=8, DRAIN=1), instance 1 the RUNLEN=1, DRAIN=0 corner.
// A per-instance monitor pops expected results queued at accept time.
module tb_outerprodrc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0]      arr_data = '0;
  logic [1:0]       rst, vld_in, abort, rdy_in;
  logic [1:0][7:0]  d0, d1;
  logic [1:0]       o_ready, o_valid, o_busy, o_en, o_clr;
  logic [1:0][31:0] o_result;
  logic [1:0][7:0]  o_d0, o_d1;

  typedef struct {
    logic [31:0] res;
    int          t;
  } exp_t;

  function automatic logic [31:0] pat(int n);
    logic [7:0] b;
    b = 8'(n);
    return {b ^ 8'hA5, b + 8'd7, ~b, b};
  endfunction

  // Array output changes every cycle so a capture on the wrong edge is visible.
  always @(negedge clk) arr_data = pat(pcyc);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, pcyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_inst
    localparam int RL = (g == 0) ? 8 : 1;
    localparam int DR = (g == 0) ? 1 : 0;

    outerprodrc_ctrl #(
      .ROWNUM(2), .COLNUM(2), .BITWIDTH(4), .OUTBITWIDTH(8), .RUNLEN(RL), .DRAIN(DR)
    ) u_dut (
      .iClk(clk), .iRst(rst[g]), .iValid(vld_in[g]), .oReady(o_ready[g]),
      .iData0(d0[g]), .iData1(d1[g]), .iAbort(abort[g]), .oValid(o_valid[g]),
      .iReady(rdy_in[g]), .oResult(o_result[g]), .oBusy(o_busy[g]), .oArrEn(o_en[g]),
      .oArrClr(o_clr[g]), .oArrData0(o_d0[g]), .oArrData1(o_d1[g]), .iArrData(arr_data)
    );

    exp_t        q[$];
    exp_t        cur;
    int          en_cnt = 0;
    int          clr_cnt = 0;
    logic        prev_valid = 1'b0;
    logic        after_abort = 1'b0;
    logic [31:0] hold_res = '0;
    logic [7:0]  e_d0 = '0;
    logic [7:0]  e_d1 = '0;

    always @(negedge clk) begin
      if (rst[g]) begin
        q.delete();
        prev_valid  = 1'b0;
        after_abort = 1'b0;
        e_d0        = '0;
        e_d1        = '0;
      end else begin
        if (after_abort) begin
          chk("abort_idle", {o_busy[g], o_en[g], o_valid[g]}, 0);
          after_abort = 1'b0;
        end
        chk("en_clr_excl", o_en[g] & o_clr[g], 0);
        chk("rdy_vld_excl", o_ready[g] & o_valid[g], 0);
        chk("arr_data0", o_d0[g], e_d0);
        chk("arr_data1", o_d1[g], e_d1);
        if (o_en[g]) en_cnt++;
        if (o_clr[g]) clr_cnt++;
        if (o_valid[g] && !prev_valid) begin
          chk("valid_has_job", q.size() > 0, 1);
          if (q.size() > 0) begin
            cur = q.pop_front();
            chk("valid_time", pcyc, cur.t);
            chk("result", o_result[g], cur.res);
            chk("en_cycles", en_cnt, RL);
            chk("clr_cycles", clr_cnt, 1);
          end
          hold_res = o_result[g];
        end else if (o_valid[g]) begin
          chk("result_hold", o_result[g], hold_res);
        end
        prev_valid = o_valid[g];
        if (abort[g] && o_busy[g]) begin
          q.delete();
          after_abort = 1'b1;
        end
        if (vld_in[g] && o_ready[g]) begin
          q.push_back('{pat(pcyc + 1 + RL + DR), pcyc + 2 + RL + DR});
          e_d0    = d0[g];
          e_d1    = d1[g];
          en_cnt  = 0;
          clr_cnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int i, logic [7:0] a, logic [7:0] b);
    bit done = 1'b0;
    d0[i] = a;
    d1[i] = b;
    vld_in[i] = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (o_ready[i]) done = 1'b1;
      step();
    end
    vld_in[i] = 1'b0;
    chk("accept_timeout", done, 1);
  endtask

  task automatic wait_done(int i);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (o_valid[i] && rdy_in[i]) seen = 1'b1;
    end
    chk("result_timeout", seen, 1);
    step();
  endtask

  task automatic wait_en(int i);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (o_en[i]) seen = 1'b1;
    end
    chk("en_timeout", seen, 1);
  endtask

  initial begin
    int nacc;
    int last;
    rst    = 2'b11;
    vld_in = '0;
    abort  = '0;
    rdy_in = 2'b11;
    d0     = '0;
    d1     = '0;

    // Reset: outputs low throughout, ready on the first cycle after.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_outs0", {o_ready[0], o_valid[0], o_busy[0], o_en[0], o_clr[0]}, 0);
      chk("rst_outs1", {o_ready[1], o_valid[1], o_busy[1], o_en[1], o_clr[1]}, 0);
    end
    step();
    rst = 2'b00;
    @(negedge clk);
    chk("post_rst_ready", o_ready[0], 1);
    chk("post_rst_busy", o_busy[0], 0);
    chk("post_rst_result", o_result[0], 0);
    chk("post_rst_arr0", o_d0[0], 0);
    step();

    // Basic job.
    send(0, 8'hE2, 8'h4C);
    wait_done(0);

    // Backpressure with a competing request held in DONE.
    rdy_in[0] = 1'b0;
    send(0, 8'h35, 8'hB1);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        if (o_valid[0]) seen = 1'b1;
      end
      chk("bp_valid_timeout", seen, 1);
    end
    step();
    d0[0] = 8'h77;
    d1[0] = 8'h88;
    vld_in[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid_held", o_valid[0], 1);
      chk("bp_ready_low", o_ready[0], 0);
      step();
    end
    rdy_in[0] = 1'b1;
    send(0, 8'h77, 8'h88);
    wait_done(0);

    // Abort at the fourth enable cycle.
    send(0, 8'h9C, 8'h21);
    wait_en(0);
    step(); step(); step();
    abort[0] = 1'b1;
    @(negedge clk);
    chk("abort_en_still_on", o_en[0], 1);
    step();
    abort[0] = 1'b0;
    @(negedge clk);
    chk("abort_en_off", o_en[0], 0);
    chk("abort_ready", o_ready[0], 1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort_no_valid", o_valid[0], 0);
    end
    step();
    // Abort alongside a request in IDLE is ignored; the job runs normally.
    abort[0] = 1'b1;
    send(0, 8'h5A, 8'hC3);
    abort[0] = 1'b0;
    wait_done(0);

    // Back-to-back with iValid held and input data changing every cycle.
    vld_in[0] = 1'b1;
    nacc = 0;
    last = 0;
    for (int k = 0; k < 80 && nacc < 4; k++) begin
      d0[0] = 8'(k * 7 + 1);
      d1[0] = 8'(k * 13 + 5);
      @(negedge clk);
      if (o_ready[0]) begin
        if (nacc > 0) chk("b2b_period", pcyc - last, 12);
        last = pcyc;
        nacc++;
      end
      step();
    end
    vld_in[0] = 1'b0;
    chk("b2b_accepts", nacc, 4);
    wait_done(0);

    // Corner: RUNLEN=1, DRAIN=0.
    send(1, 8'h13, 8'h9F);
    @(negedge clk);
    chk("corner_clr", {o_clr[1], o_en[1]}, 2'b10);
    @(negedge clk);
    chk("corner_en", {o_clr[1], o_en[1]}, 2'b01);
    @(negedge clk);
    chk("corner_valid", o_valid[1], 1);
    step();

    // Reset during DRAIN drops the job.
    send(0, 8'h42, 8'h24);
    wait_en(0);
    for (int k = 0; k < 8; k++) step();
    chk("in_drain", {o_busy[0], o_en[0], o_clr[0]}, 3'b100);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("drain_rst_busy", o_busy[0], 0);
    step();
    rst[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("drain_rst_no_valid", o_valid[0], 0);
    end
    chk("drain_rst_result", o_result[0], 0);
    chk("drain_rst_ready", o_ready[0], 1);

    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
    $fatal(1);
  end

endmodule
